cordic_sqrt_pre: RTL and testbench

Front-end normalisation stage of the CORDIC square-root pipeline. It accepts an unsigned integer operand a and factors it as a = m·4^k, with m in [0.25, 1). It then forms the hyperbolic seed x0 = m + 0.25, y0 = m − 0.25, z0 = 0 in signed fixed point. It feeds iteration stage 1 directly and forwards k so the post stage can rescale the result by 2^k.

---
 rtl/cordic_sqrt_pre_if.sv | 37 +++
 rtl/cordic_sqrt_pre.sv | 68 ++++++
 tb/tb_cordic_sqrt_pre.sv | 108 ++++++++++
 3 files changed

// File: rtl/cordic_sqrt_pre_if.sv
// cordic_sqrt_pre_if: operand/seed handshake bus for the CORDIC sqrt front end.
// Carries out_zero only when CORDIC_PRE_ZERO_DETECT_EN is defined.
interface cordic_sqrt_pre_if #(
  parameter int IN_WIDTH  = 16,
  parameter int SYM_WIDTH = 1,
  parameter int INT_WIDTH = 1,
  parameter int DEC_WIDTH = 14,
  parameter int K_WIDTH   = $clog2(IN_WIDTH/2+1)
);
  localparam int FW = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;
  logic                in_valid;
  logic                in_ready;
  logic [IN_WIDTH-1:0] a;
  logic                out_valid;
  logic                out_ready;
  logic [FW-1:0]       x0;
  logic [FW-1:0]       y0;
  logic [FW-1:0]       z0;
  logic [K_WIDTH-1:0]  k;
`ifdef CORDIC_PRE_ZERO_DETECT_EN
  logic                out_zero;
`endif
  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, x0, y0, z0, k
`ifdef CORDIC_PRE_ZERO_DETECT_EN
    , out_zero
`endif
  );
  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, x0, y0, z0, k
`ifdef CORDIC_PRE_ZERO_DETECT_EN
    , out_zero
`endif
  );
endinterface

// File: rtl/cordic_sqrt_pre.sv
// cordic_sqrt_pre: factors a = m*4^k and emits the hyperbolic seed x0=m+0.25, y0=m-0.25, z0=0.
// CORDIC_PRE_ZERO_DETECT_EN adds out_zero and forces a zero seed for a = 0.
module cordic_sqrt_pre #(
  parameter int IN_WIDTH  = 16,
  parameter int SYM_WIDTH = 1,
  parameter int INT_WIDTH = 1,
  parameter int DEC_WIDTH = 14,
  parameter int K_WIDTH   = $clog2(IN_WIDTH/2+1)
) (
  input logic clk,
  input logic rst,
  cordic_sqrt_pre_if.slave io
);
  localparam int FW = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;
  localparam int PW = $clog2(IN_WIDTH);
  localparam logic [FW-1:0] Q = FW'(1) << (DEC_WIDTH - 2);
  logic                en;
  logic                s1_valid;
  logic [IN_WIDTH-1:0] s1_a;
  logic [K_WIDTH-1:0]  s1_k;
  logic [K_WIDTH-1:0]  k_next;
  logic [PW-1:0]       p;
  logic [FW-1:0]       m_fix;
`ifdef CORDIC_PRE_ZERO_DETECT_EN
  logic                a_zero;
  assign a_zero = s1_a == '0;
`endif
  assign en = !io.out_valid || io.out_ready;
  assign io.in_ready = en;
  always_comb begin
    p = '0;
    for (int i = 0; i < IN_WIDTH; i++)
      if (io.a[i]) p = PW'(i);
  end
  assign k_next = (io.a == '0) ? '0 : K_WIDTH'(p >> 1) + K_WIDTH'(1);
  // a * 2^(DEC-2k) in one shift: pre-scale by 2^DEC, then drop 2k bits (truncating)
  assign m_fix = FW'({s1_a, {DEC_WIDTH{1'b0}}} >> {s1_k, 1'b0});
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_a         <= '0;
      s1_k         <= '0;
      io.out_valid <= 1'b0;
      io.x0        <= '0;
      io.y0        <= '0;
      io.z0        <= '0;
      io.k         <= '0;
`ifdef CORDIC_PRE_ZERO_DETECT_EN
      io.out_zero  <= 1'b0;
`endif
    end else if (en) begin
      s1_valid     <= io.in_valid;
      s1_a         <= io.a;
      s1_k         <= k_next;
      io.out_valid <= s1_valid;
      io.k         <= s1_k;
      io.z0        <= '0;
`ifdef CORDIC_PRE_ZERO_DETECT_EN
      io.x0        <= a_zero ? '0 : m_fix + Q;
      io.y0        <= a_zero ? '0 : m_fix - Q;
      io.out_zero  <= a_zero;
`else
      io.x0        <= m_fix + Q;
      io.y0        <= m_fix - Q;
`endif
    end
  end
endmodule

// File: tb/tb_cordic_sqrt_pre.sv
// tb_cordic_sqrt_pre: directed vectors for the CORDIC sqrt front end with hand-computed seeds.
module tb_cordic_sqrt_pre;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  cordic_sqrt_pre_if bus ();
  cordic_sqrt_pre dut (.clk(clk), .rst(rst), .io(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic send_one(input logic [15:0] av, input logic [31:0] ek, ex, ey, ez);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = av;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 chk("lat_early", bus.out_valid, 0);
    @(negedge clk);
    #1;
    chk("valid", bus.out_valid, 1);
    chk("k", bus.k, ek);
    chk("x0", bus.x0, ex);
    chk("y0", bus.y0, ey);
    chk("z0", bus.z0, 0);
`ifdef CORDIC_PRE_ZERO_DETECT_EN
    chk("out_zero", bus.out_zero, ez);
`else
    chk("ez_unused", ez, ez & 32'h0);
`endif
    @(negedge clk);
    #1 chk("bubble", bus.out_valid, 0);
  endtask

  logic [15:0] vec_a [3] = '{16'd1, 16'd10, 16'hFFFF};
  logic [15:0] vec_x [3] = '{16'h2000, 16'h3800, 16'h4FFF};
  logic [15:0] vec_y [3] = '{16'h0000, 16'h1800, 16'h2FFF};
  int got;

  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_x0", bus.x0, 0);
    chk("rst_y0", bus.y0, 0);
    chk("rst_k", bus.k, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_in_ready", bus.in_ready, 1);

    send_one(16'd1, 1, 32'h2000, 32'h0000, 0);
    send_one(16'd10, 2, 32'h3800, 32'h1800, 0);
    send_one(16'hFFFF, 8, 32'h4FFF, 32'h2FFF, 0);
`ifdef CORDIC_PRE_ZERO_DETECT_EN
    send_one(16'd0, 0, 32'h0000, 32'h0000, 1);
`else
    send_one(16'd0, 0, 32'h1000, 32'hF000, 0);
`endif

    // back-to-back stream with downstream stall on cycles 3..5
    got = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus.in_valid = c < 3;
      bus.a = (c < 3) ? vec_a[c] : 16'h0;
      bus.out_ready = !(c >= 3 && c <= 5);
      #1;
      if (bus.out_valid && got < 3) begin
        chk("strm_x0", bus.x0, vec_x[got]);
        chk("strm_y0", bus.y0, vec_y[got]);
        if (bus.out_ready) got++;
        else chk("stall_in_ready", bus.in_ready, 0);
      end else if (bus.out_valid) chk("strm_extra", 1, 0);
    end
    chk("strm_count", got, 3);

    // reset with two items in flight
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 16'd1;
    @(negedge clk);
    bus.a = 16'd10;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 chk("pre_rst_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_x0", bus.x0, 0);
    chk("mid_rst_y0", bus.y0, 0);
    chk("mid_rst_k", bus.k, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 chk("post_rst_idle", bus.out_valid, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
